// File: rtl/float_div_pipeline_if.sv
// Request/acknowledge bus of the iterative float divider: operands in, result plus status out.
interface float_div_pipeline_if #(
  parameter int float_width = 32
);
  logic                   req;
  logic [float_width-1:0] a;
  logic [float_width-1:0] b;
  logic [float_width-1:0] out;
  logic                   ack;
  logic                   busy;

  modport master (output req, a, b, input out, ack, busy);
  modport slave  (input req, a, b, output out, ack, busy);
endinterface

// File: rtl/float_div_pipeline.sv
// Iterative single-precision divider: radix-2 restoring mantissa division, one quotient bit
// per cycle, truncating result; zero operands skip the iteration and complete in one cycle.
module float_div_pipeline #(
  parameter int float_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  float_div_pipeline_if.slave  bus
);
  localparam int exp_msb  = float_width - 2;
  localparam int frac_msb = float_width - 10;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORMALIZE, PACK} state_t;

  state_t             state;
  logic               sign;
  logic               za;
  logic               zb;
  logic signed [9:0]  exp;
  logic [23:0]        mb;
  logic [25:0]        rem;
  logic [24:0]        q;
  logic [4:0]         cnt;
  logic [22:0]        mant;
  logic [31:0]        out_r;
  logic               ack_r;
  logic               busy_r;

  logic [7:0]  ea;
  logic [7:0]  eb;
  logic        za_in;
  logic        zb_in;
  logic        rem_ge;
  logic [25:0] rem_sub;

  assign ea      = bus.a[exp_msb -: 8];
  assign eb      = bus.b[exp_msb -: 8];
  assign za_in   = (ea == 8'd0);
  assign zb_in   = (eb == 8'd0);
  assign rem_ge  = (rem >= {2'b00, mb});
  assign rem_sub = rem - {2'b00, mb};

  assign bus.out  = out_r;
  assign bus.ack  = ack_r;
  assign bus.busy = busy_r;

  // NOTE: state and datapath are all non-blocking so every branch below reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sign   <= 1'b0;
      za     <= 1'b0;
      zb     <= 1'b0;
      exp    <= '0;
      mb     <= '0;
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      mant   <= '0;
      out_r  <= '0;
      ack_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_r <= 1'b0;
          if (bus.req) begin
            sign   <= bus.a[float_width-1] ^ bus.b[float_width-1];
            za     <= za_in;
            zb     <= zb_in;
            exp    <= {2'b00, ea} - {2'b00, eb} + 10'd127;
            mb     <= {1'b1, bus.b[frac_msb:0]};
            rem    <= {2'b01, bus.a[frac_msb:0]};
            q      <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= (za_in || zb_in) ? PACK : DIVIDE;
          end
        end
        DIVIDE: begin
          if (rem_ge) begin
            rem <= rem_sub << 1;
            q   <= {q[23:0], 1'b1};
          end else begin
            rem <= rem << 1;
            q   <= {q[23:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd24) state <= NORMALIZE;
        end
        NORMALIZE: begin
          // Quotient lies in (0.5, 2): either the integer bit is set or one left shift fixes it.
          if (q[24]) begin
            mant <= q[23:1];
          end else begin
            mant <= q[22:0];
            exp  <= exp - 10'sd1;
          end
          state <= PACK;
        end
        PACK: begin
          if (za && zb)             out_r <= 32'h7FC0_0000;
          else if (zb)              out_r <= {sign, 8'hFF, 23'h0};
          else if (za)              out_r <= {sign, 31'h0};
          else if (exp <= 10'sd0)   out_r <= {sign, 31'h0};
          else if (exp >= 10'sd255) out_r <= {sign, 8'hFF, 23'h0};
          else                      out_r <= {sign, exp[7:0], mant};
          ack_r  <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/float_div_pipeline.md
# float_div_pipeline

Iterative IEEE-754 single-precision divider with the same `req`/`ack` handshake as the float multiplier, computing `out = a / b`. It is the inverse-operation counterpart in the float unit. It uses a radix-2 restoring mantissa divider that retires one quotient bit per cycle. Special operands (zero, divide-by-zero) bypass the iteration and complete early.

## Interface
- `float_width`, default 32: operand width. Only 32 is supported (8-bit exponent, 23-bit fraction, bias 127).
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  1: request. Sampled only in IDLE.
- `a`  in  32: dividend. Captured on the accepting edge.
- `b`  in  32: divisor. Captured on the accepting edge.
- `out`  out  32: result. Valid when `ack`=1, and held until the next result or reset.
- `ack`  out  1: single-cycle completion pulse.
- `busy`  out  1: high in every state except IDLE.

## Operation
- **States:** IDLE, DIVIDE, NORMALIZE, PACK.
- **IDLE:**
  - Clear `ack`.
  - If `req`=1, capture `a` and `b` and compute the flags below.
    - `sign = a[31]^b[31]`.
    - `za = (a[30:23]==0)`, `zb = (b[30:23]==0)`. Denormals are treated as zero.
  - If `za` or `zb`, go to PACK with the special flag set. Otherwise go to DIVIDE.
- **DIVIDE setup (on the accepting edge):**
  - `exp = {2'b0,ea} - {2'b0,eb} + 127`, held as a 10-bit signed value.
  - `ma = {1,a[22:0]}`, `mb = {1,b[22:0]}`.
  - Remainder register (26 bits) is loaded with `ma`. Quotient `q[24:0]` is cleared. Iteration counter is set to 0.
- **DIVIDE (25 cycles, counter 0..24):**
  - Each cycle: if `rem >= mb`, then `rem <= (rem-mb)<<1` and the next q bit is 1. Otherwise `rem <= rem<<1` and the next q bit is 0.
  - q fills MSB-first. `q[24]` is the integer bit; `q[23:0]` are fraction bits.
  - After counter 24, go to NORMALIZE.
- **NORMALIZE:**
  - If `q[24]`: `mant = q[23:1]`, `exp` unchanged.
  - Else: `mant = q[22:0]`, `exp = exp-1`.
  - Truncate with no rounding, matching the multiplier.
- **PACK** writes `out`, pulses `ack`, and returns to IDLE.
  - Special cases, in priority order:
    1. `za && zb`: `0x7FC00000`.
    2. `zb`: `{sign,8'hFF,23'h0}`.
    3. `za`: `{sign,31'h0}`.
  - Normal path, by signed `exp`:
    - `exp <= 0`: `{sign,31'h0}` (flush to zero).
    - `exp >= 255`: `{sign,8'hFF,23'h0}` (infinity).
    - Otherwise: `{sign,exp[7:0],mant}`.
- Exponent 255 inputs (Inf/NaN) are processed as ordinary numbers. IEEE-correct handling of them is out of scope.
- `req` in any state other than IDLE is ignored. It is not queued.

## Timing
- **Reset values:** state IDLE, `ack`=0, `out`=0, `busy`=0, and all internal registers 0.
- **Reset mid-operation:** `rst`=1 at any edge aborts the operation. No `ack` is produced for it.
- **Normal latency:** let E0 be the accepting edge.
  - DIVIDE occupies E1..E25.
  - NORMALIZE updates at E26.
  - PACK at E27 sets `ack` and `out`.
  - `ack` is high for the cycle following E27, then cleared at E28.
- **Special-operand latency:** PACK at E1. `ack` is high for the cycle after E1.
- **`busy`:** high from the cycle after E0 until the PACK edge. It is low in the cycle in which `ack` is high.
- **Back-to-back:** `req`=1 during the `ack` cycle is accepted on that edge. The next operand capture coincides with clearing `ack`.
- **Output stability:** `out` changes only at PACK edges or reset.

## Test plan
- **Basic divide:** 6.0/2.0 (`a`=0x40C00000, `b`=0x40000000) -> `out`=0x40400000. `ack` pulses exactly 1 cycle, 27 edges after accept. `busy` is high for 27 cycles.
- **Truncation and normalize shift:** 1.0/3.0 (0x3F800000 / 0x40400000) -> 0x3EAAAAAA. -1.5/0.5 (0xBFC00000 / 0x3F000000) -> 0xC0400000.
- **Special operands (ack after 1 edge):**
  - 0x3F800000/0x00000000 -> 0x7F800000.
  - 0x80000000/0x3F800000 -> 0x80000000.
  - 0x00000000/0x00000000 -> 0x7FC00000.
- **Exponent bounds:**
  - 0x7F000000/0x3E800000 -> 0x7F800000 (overflow).
  - 0x00800000/0x40000000 -> 0x00000000 (underflow flush).
- **Handshake:**
  - Hold `req`=1 continuously with alternating operands. Every result is correct, one accept per `ack` cycle, and no `req` is taken while `busy`.
- **Reset mid-DIVIDE:**
  - Assert `rst` for 1 cycle at E10. Expect `ack` never asserted for that operation, `out`=0, `busy`=0.
  - Then issue 6.0/2.0. Expect 0x40400000 with normal latency.
